// File: rtl/odometer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// odometer_pkg : shared types and helpers for the ring-oscillator odometer
// Rev 1.0
// ----------------------------------------------------------------------------
package odometer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STRESS = 3'd1,
    ST_SETTLE = 3'd2,
    ST_MEAS   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] SEL_ENC_INV  = 2'd0;
  localparam logic [1:0] SEL_ENC_NAND = 2'd1;
  localparam logic [1:0] SEL_ENC_NOR  = 2'd2;
  localparam logic [1:0] SEL_ILLEGAL  = 2'd3;

  // Returns {nor, nand, inv}; the illegal code selects no chain.
  function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
    logic [2:0] oh;
    oh = 3'b000;
    case (sel)
      SEL_ENC_INV:  oh = 3'b001;
      SEL_ENC_NAND: oh = 3'b010;
      SEL_ENC_NOR:  oh = 3'b100;
      default:      oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rosc_edge_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rosc_edge_counter : synchronizes the oscillator output and counts its rising
// edges into a saturating counter with a sticky saturation flag.
// Rev 1.0
// ----------------------------------------------------------------------------
module rosc_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rosc_in,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_hist;
  logic [CNT_W-1:0] r_count;
  logic             r_sat;
  logic             w_edge;

  assign w_edge = r_sync2 & ~r_hist;
  assign count  = r_count;
  assign sat    = r_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_sync1 <= rosc_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      if (clr) begin
        r_count <= '0;
        r_sat   <= 1'b0;
      end else if (en && w_edge) begin
        // An edge arriving at full scale is dropped and flagged.
        if (r_count == c_cnt_max) r_sat <= 1'b1;
        else                      r_count <= r_count + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/odometer_meas_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// odometer_meas_sequencer : runs one stress / settle / measure cycle of the
// three-chain ring-oscillator odometer and returns the edge count.
// Rev 1.0
// ----------------------------------------------------------------------------
module odometer_meas_sequencer
  import odometer_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int STRESS_W   = 24,
  parameter int SETTLE_CYC = 8,
  parameter int WIN_CYC    = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_sel,
  input  logic                cmd_ac,
  input  logic [STRESS_W-1:0] cmd_stress_cyc,
  input  logic                abort,
  input  logic                rosc_out,
  output logic                sel_inv,
  output logic                sel_nand,
  output logic                sel_nor,
  output logic                start,
  output logic                ac_dc,
  output logic                en_power_rosc,
  output logic                en_rosc,
  output logic                meas_stress,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [CNT_W-1:0]    res_count,
  output logic                res_sat,
  output logic                res_err,
  output logic                busy
);

  localparam int c_phase_max = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
  localparam int c_phase_w   = $clog2(c_phase_max);
  localparam logic [c_phase_w-1:0] c_settle_load = c_phase_w'(SETTLE_CYC - 1);
  localparam logic [c_phase_w-1:0] c_win_load    = c_phase_w'(WIN_CYC - 1);

  state_t                r_state;
  state_t                w_nxt;
  logic [STRESS_W-1:0]   r_stress_cnt;
  logic [c_phase_w-1:0]  r_phase_cnt;
  logic [1:0]            r_sel;
  logic                  r_ac;
  logic                  w_accept;
  logic [1:0]            w_sel_eff;
  logic                  w_ac_eff;
  logic [2:0]            w_sel_oh;
  logic                  w_nxt_stress;
  logic                  w_nxt_run;
  logic                  w_cnt_clr;
  logic                  w_cnt_en;

  assign w_accept  = cmd_valid & cmd_ready & ~abort;
  // Outputs are registered from the next state, so the command fields must be
  // taken straight from the port on the accepting edge.
  assign w_sel_eff = w_accept ? cmd_sel : r_sel;
  assign w_ac_eff  = w_accept ? cmd_ac  : r_ac;
  assign w_sel_oh  = sel_onehot(w_sel_eff);

  assign w_nxt_stress = (w_nxt == ST_STRESS);
  assign w_nxt_run    = (w_nxt == ST_SETTLE) || (w_nxt == ST_MEAS);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (cmd_sel == SEL_ILLEGAL)     w_nxt = ST_DONE;
          else if (cmd_stress_cyc != '0)  w_nxt = ST_STRESS;
          else                            w_nxt = ST_SETTLE;
        end
      end
      ST_STRESS: if (r_stress_cnt == STRESS_W'(1)) w_nxt = ST_SETTLE;
      ST_SETTLE: if (r_phase_cnt == '0)            w_nxt = ST_MEAS;
      ST_MEAS:   if (r_phase_cnt == '0)            w_nxt = ST_DONE;
      ST_DONE:   if (res_ready)                    w_nxt = ST_IDLE;
      default:                                     w_nxt = ST_IDLE;
    endcase
    if (abort && (r_state != ST_IDLE)) w_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_stress_cnt  <= '0;
      r_phase_cnt   <= '0;
      r_sel         <= 2'd0;
      r_ac          <= 1'b0;
      cmd_ready     <= 1'b1;
      busy          <= 1'b0;
      res_valid     <= 1'b0;
      res_err       <= 1'b0;
      start         <= 1'b0;
      ac_dc         <= 1'b0;
      en_power_rosc <= 1'b0;
      en_rosc       <= 1'b0;
      meas_stress   <= 1'b0;
      sel_inv       <= 1'b0;
      sel_nand      <= 1'b0;
      sel_nor       <= 1'b0;
    end else begin
      r_state <= w_nxt;

      if (w_accept) begin
        r_sel <= cmd_sel;
        r_ac  <= cmd_ac;
      end

      if (w_accept)                   r_stress_cnt <= cmd_stress_cyc;
      else if (r_state == ST_STRESS)  r_stress_cnt <= r_stress_cnt - STRESS_W'(1);

      if ((w_nxt == ST_SETTLE) && (r_state != ST_SETTLE))    r_phase_cnt <= c_settle_load;
      else if ((w_nxt == ST_MEAS) && (r_state != ST_MEAS))   r_phase_cnt <= c_win_load;
      else if (r_phase_cnt != '0)                            r_phase_cnt <= r_phase_cnt - c_phase_w'(1);

      if (w_accept)              res_err <= (cmd_sel == SEL_ILLEGAL);
      else if (w_nxt == ST_IDLE) res_err <= 1'b0;

      cmd_ready     <= (w_nxt == ST_IDLE);
      busy          <= (w_nxt != ST_IDLE);
      res_valid     <= (w_nxt == ST_DONE);
      start         <= w_nxt_stress;
      ac_dc         <= w_nxt_stress & w_ac_eff;
      en_power_rosc <= w_nxt_stress | w_nxt_run;
      en_rosc       <= w_nxt_run;
      meas_stress   <= w_nxt_run;
      sel_inv       <= w_nxt_run & w_sel_oh[0];
      sel_nand      <= w_nxt_run & w_sel_oh[1];
      sel_nor       <= w_nxt_run & w_sel_oh[2];
    end
  end

  // Clearing in IDLE as well keeps the count at zero for rejected commands.
  assign w_cnt_clr = (r_state == ST_IDLE) || (r_state == ST_SETTLE);
  assign w_cnt_en  = (r_state == ST_MEAS);

  rosc_edge_counter #(
    .CNT_W (CNT_W)
  ) u_edge_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .rosc_in (rosc_out),
    .clr     (w_cnt_clr),
    .en      (w_cnt_en),
    .count   (res_count),
    .sat     (res_sat)
  );

endmodule
`default_nettype wire
